// File: rtl/fma_pkg.sv
// Shared constants and state type for the FMA normalization path.
package fma_pkg;

  localparam int unsigned NF     = 52;
  localparam int unsigned NE     = 11;
  localparam int unsigned FMALEN = 3 * NF + 6;
  localparam int unsigned STEP   = 32;

  typedef enum logic [1:0] {
    NS_IDLE,
    NS_SHIFT,
    NS_DONE
  } normstate_t;

endpackage

// File: rtl/fma_lzc_step.sv
// Leading-zero counter over one STEP-bit window; an all-zero window reports STEP.
module fma_lzc_step #(
  parameter int unsigned STEP = 32
) (
  input  logic [STEP-1:0]      i_data,
  output logic [$clog2(STEP):0] o_count
);

  localparam int unsigned CW = $clog2(STEP) + 1;

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_count = CW'(STEP);
    for (int i = 0; i < STEP; i++) begin
      if (i_data[i]) o_count = CW'(STEP - 1 - i);
    end
  end

endmodule

// File: rtl/fma_norm_seq.sv
// Iterative left-normalizer for the FMA sum: shifts up to STEP bits per cycle until the
// leading 1 reaches the MSB or the exponent clamps at 1.
module fma_norm_seq #(
  parameter int unsigned NF     = fma_pkg::NF,
  parameter int unsigned NE     = fma_pkg::NE,
  parameter int unsigned FMALEN = 3 * NF + 6,
  parameter int unsigned STEP   = fma_pkg::STEP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [FMALEN-1:0]        Sm,
  input  logic signed [NE+1:0]     Se,
  input  logic                     SStickyIn,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [FMALEN-1:0]        Mf,
  output logic signed [NE+1:0]     Me,
  output logic                     SSticky,
  output logic                     SumZero
);

  import fma_pkg::*;

  localparam int unsigned CW = $clog2(STEP) + 1;
  localparam int unsigned EW = NE + 2;
  localparam logic signed [EW-1:0] EOne = 1;

  normstate_t r_state, w_state_next;

  logic [FMALEN-1:0]     r_m;
  logic signed [EW-1:0]  r_e;
  logic                  r_sticky;
  logic                  r_zero;

  logic [CW-1:0] w_lzc;
  logic [EW-1:0] w_lzc_ext;
  logic [EW-1:0] w_lim;
  logic [EW-1:0] w_amt;
  logic          w_shift_last;
  logic          w_accept;

  fma_lzc_step #(
    .STEP (STEP)
  ) u_lzc (
    .i_data  (r_m[FMALEN-1 -: STEP]),
    .o_count (w_lzc)
  );

  // In SHIFT the exponent is always >= 2, so lim is positive and unsigned compares suffice.
  assign w_lzc_ext    = EW'(w_lzc);
  assign w_lim        = r_e - EOne;
  assign w_amt        = (w_lzc_ext < w_lim) ? w_lzc_ext : w_lim;
  assign w_shift_last = ~w_lzc[CW-1] | (w_lim <= w_lzc_ext);
  assign w_accept     = InValid & InReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= NS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = NS_IDLE;
    end else begin
      unique case (r_state)
        NS_IDLE: begin
          if (InValid) begin
            w_state_next = ((Sm == '0) || (Se <= EOne)) ? NS_DONE : NS_SHIFT;
          end
        end
        NS_SHIFT: begin
          if (w_shift_last) w_state_next = NS_DONE;
        end
        NS_DONE: begin
          if (OutReady) w_state_next = NS_IDLE;
        end
        default: w_state_next = NS_IDLE;
      endcase
    end
  end

  always_comb begin
    InReady  = (r_state == NS_IDLE) & ~flush;
    OutValid = (r_state == NS_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m      <= '0;
      r_e      <= '0;
      r_sticky <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_sticky <= SStickyIn;
      if (Sm == '0) begin
        r_m    <= '0;
        r_e    <= '0;
        r_zero <= 1'b1;
      end else begin
        r_m    <= Sm;
        r_e    <= Se;
        r_zero <= 1'b0;
      end
    end else if (r_state == NS_SHIFT) begin
      r_m <= r_m << w_amt;
      r_e <= r_e - $signed(w_amt);
    end
  end

  assign Mf      = r_m;
  assign Me      = r_e;
  assign SSticky = r_sticky;
  assign SumZero = r_zero;

endmodule

// File: tb/tb_fma_norm_seq.sv
// Scoreboard bench for fma_norm_seq with a closed-form normalization model.
module tb_fma_norm_seq;

  localparam int L = 162;

  typedef struct {
    logic [L-1:0]       m;
    logic signed [12:0] e;
    logic               st;
    logic               z;
    int                 cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               flush = 1'b0;
  logic               InValid = 1'b0;
  logic               InReady;
  logic [L-1:0]       Sm = '0;
  logic signed [12:0] Se = '0;
  logic               SStickyIn = 1'b0;
  logic               OutValid;
  logic               OutReady = 1'b1;
  logic [L-1:0]       Mf;
  logic signed [12:0] Me;
  logic               SSticky;
  logic               SumZero;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fma_norm_seq dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .InValid   (InValid),
    .InReady   (InReady),
    .Sm        (Sm),
    .Se        (Se),
    .SStickyIn (SStickyIn),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Mf        (Mf),
    .Me        (Me),
    .SSticky   (SSticky),
    .SumZero   (SumZero)
  );

  // Total shift = min(leading zeros, Se-1); cycle count follows from whichever limit binds.
  function automatic exp_t model(input logic [L-1:0] sm, input int se, input logic st);
    exp_t r;
    int lz, lim, tot;
    r.st = st;
    r.z = 1'b0;
    if (sm == '0) begin
      r.m = '0; r.e = '0; r.z = 1'b1; r.cyc = 0;
    end else if (se <= 1) begin
      r.m = sm; r.e = 13'(se); r.cyc = 0;
    end else begin
      lz = 0;
      for (int i = L - 1; i >= 0 && !sm[i]; i--) lz++;
      lim = se - 1;
      if (lz < lim) begin
        tot = lz; r.cyc = lz / 32 + 1;
      end else begin
        tot = lim; r.cyc = (lim + 31) / 32;
      end
      r.m = sm << tot;
      r.e = 13'(se - tot);
    end
    return r;
  endfunction

  task automatic run_op(input logic [L-1:0] sm, input int se, input logic st, input int hold);
    exp_t ex;
    int   n;
    ex = model(sm, se, st);
    @(negedge clk);
    vectors++;
    if (InReady !== 1'b1) begin
      miscompares++;
      $display("FAIL in_ready_before_op: got %b want 1", InReady);
    end
    Sm = sm; Se = 13'(se); SStickyIn = st; InValid = 1'b1; OutReady = (hold == 0);
    @(posedge clk);
    #1 InValid = 1'b0;
    q.push_back(ex);
    @(negedge clk);
    n = 0;
    while (OutValid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ex = q.pop_front();
    vectors++;
    if (OutValid !== 1'b1) begin
      miscompares++;
      $display("FAIL out_valid_timeout: no OutValid after %0d cycles (Sm=%h Se=%0d)", n, sm, se);
      OutReady = 1'b1;
      return;
    end
    vectors++;
    if (n !== ex.cyc) begin
      miscompares++;
      $display("FAIL shift_cycles: got %0d want %0d (Sm=%h Se=%0d)", n, ex.cyc, sm, se);
    end
    vectors++;
    if (Mf !== ex.m) begin
      miscompares++;
      $display("FAIL mf: got %h want %h (Se=%0d)", Mf, ex.m, se);
    end
    vectors++;
    if (Me !== ex.e) begin
      miscompares++;
      $display("FAIL me: got %0d want %0d", Me, ex.e);
    end
    vectors++;
    if (SSticky !== ex.st || SumZero !== ex.z) begin
      miscompares++;
      $display("FAIL sticky_zero: got %b%b want %b%b", SSticky, SumZero, ex.st, ex.z);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      vectors++;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || Mf !== ex.m || Me !== ex.e ||
          SSticky !== ex.st || SumZero !== ex.z) begin
        miscompares++;
        $display("FAIL hold_stable: cycle %0d ov=%b ir=%b me=%0d want ov=1 ir=0 me=%0d",
                 k, OutValid, InReady, Me, ex.e);
      end
    end
    OutReady = 1'b1;
    @(negedge clk);
    vectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      miscompares++;
      $display("FAIL after_handshake: ov=%b ir=%b want ov=0 ir=1", OutValid, InReady);
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || Mf !== '0 || Me !== '0 ||
        SSticky !== 1'b0 || SumZero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: ov=%b ir=%b me=%0d st=%b z=%b want 0 1 0 0 0",
               OutValid, InReady, Me, SSticky, SumZero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_msb;
    run_op(162'd1 << 161, 100, 1'b0, 0);
  endtask

  task automatic test_multi_shift;
    run_op(162'd1, 1000, 1'b1, 0);
  endtask

  task automatic test_clamp;
    run_op(162'd1 << 100, 20, 1'b0, 0);
    run_op(162'd1 << 100, 0, 1'b1, 0);
    run_op(162'd1 << 100, 1, 1'b0, 0);
    run_op(162'd1 << 100, 2, 1'b0, 0);
    run_op(162'd1 << 129, 33, 1'b0, 0);
    run_op(162'd1 << 129, 34, 1'b0, 0);
    run_op(162'd5 << 40, -7, 1'b1, 0);
  endtask

  task automatic test_zero;
    run_op('0, 500, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    run_op(162'd3 << 70, 60, 1'b1, 5);
  endtask

  task automatic test_back_to_back;
    logic [191:0] t;
    logic [L-1:0] sm;
    int           se;
    for (int i = 0; i < 8; i++) begin
      t  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sm = t[L-1:0] >> $urandom_range(0, 161);
      se = int'($urandom_range(0, 400)) - 50;
      run_op(sm, se, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic test_flush;
    int seen;
    @(negedge clk);
    Sm = 162'd1; Se = 13'd1000; SStickyIn = 1'b1; InValid = 1'b1;
    @(posedge clk);
    #1 InValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_shift: ov=%b ir=%b want ov=0 ir=1", OutValid, InReady);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (OutValid === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL flush_no_output: OutValid seen %0d cycles want 0", seen);
    end
    // Flush in IDLE must block an offered input.
    @(negedge clk);
    Sm = 162'd1 << 161; Se = 13'd100; flush = 1'b1; InValid = 1'b1;
    #1;
    vectors++;
    if (InReady !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_in_ready: got %b want 0", InReady);
    end
    @(posedge clk);
    #1 InValid = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (OutValid === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL flush_idle_accept: OutValid seen %0d cycles want 0", seen);
    end
    run_op(162'd1 << 10, 300, 1'b0, 0);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    Sm = 162'd1; Se = 13'd1000; SStickyIn = 1'b1; InValid = 1'b1;
    @(posedge clk);
    #1 InValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || Mf !== '0 || Me !== '0 ||
        SSticky !== 1'b0 || SumZero !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: ov=%b ir=%b me=%0d st=%b z=%b want 0 1 0 0 0",
               OutValid, InReady, Me, SSticky, SumZero);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(162'd1, 1000, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_msb();
    test_multi_shift();
    test_clamp();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
